// File: rtl/mv_pkg.sv
// Shared types for the matrix-vector stream controller:
// the controller state encoding and the result-width helper.
package mv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MAT,
        LOAD_VEC,
        START,
        WAIT,
        DRAIN
    } mv_state_e;

    // A dot product of n terms of dw-bit operands needs 2*dw bits plus log2(n) carry bits.
    function automatic int res_w(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/mv_skid_fifo.sv
// Two-entry skid FIFO with a registered head, so popData_o/popValid_o come straight from flops.
// A push is accepted when full if a pop happens in the same cycle.
module mv_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pushValid_i,
    input  logic [W-1:0] pushData_i,
    output logic         pushReady_o,
    output logic         popValid_o,
    input  logic         popReady_i,
    output logic [W-1:0] popData_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         push;
    logic         pop;

    assign popValid_o  = (count_q != 2'd0);
    assign popData_o   = head_q;
    assign count_o     = count_q;
    assign pushReady_o = (count_q != 2'd2) || popReady_i;
    assign push        = pushValid_i && pushReady_o;
    assign pop         = popValid_o && popReady_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = pushData_i;
                else                 tail_d = pushData_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = pushData_i;
                end else begin
                    head_d = pushData_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mv_stream_ctrl.sv
// Host-side controller: streams a matrix and vector into the ROM banks, pulses start,
// waits for compute_done, then drains N results from the result RAM as a valid/ready stream.
module mv_stream_ctrl
    import mv_pkg::*;
#(
    parameter  int N          = 2,
    parameter  int DW         = 8,
    parameter  int BRAM_DEPTH = 2,
    localparam int AW         = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1,
    localparam int RW         = res_w(N, DW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    output logic [N-1:0][DW-1:0]  rom_mat_data,
    output logic [N-1:0][AW-1:0]  rom_mat_wr_addr,
    output logic [N-1:0]          rom_mat_we,
    output logic [DW-1:0]         rom_vec_data,
    output logic [AW-1:0]         rom_vec_wr_addr,
    output logic                  rom_vec_we,
    output logic                  start,
    input  logic                  compute_done,
    output logic [AW-1:0]         ram_rd_addr,
    input  logic [RW-1:0]         ram_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RW-1:0]         out_data,
    output logic                  busy
);

    localparam int             CW       = $clog2(N + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0]  COUNT_N  = CW'(N);

    mv_state_e      state_q, state_d;
    logic [CW-1:0]  rowCnt_q, rowCnt_d;
    logic [CW-1:0]  colCnt_q, colCnt_d;
    logic [CW-1:0]  rdCnt_q, rdCnt_d;
    logic [CW-1:0]  outCnt_q, outCnt_d;
    logic [N-1:0]   matWe_q, matWe_d;
    logic           vecWe_q, vecWe_d;
    logic [AW-1:0]  wrAddr_q, wrAddr_d;
    logic [DW-1:0]  wrData_q, wrData_d;
    logic           inflight_q, inflight_d;

    logic           accept;
    logic           lastMatElem;
    logic           loadDone;
    logic           drainLast;
    logic           rdIssue;
    logic           fifoPushReady;
    logic           fifoPop;
    logic [1:0]     fifoCount;

    assign accept      = in_valid && in_ready;
    assign lastMatElem = (rowCnt_q == LAST_IDX) && (colCnt_q == LAST_IDX);
    // colCnt reaching N marks the cycle the final vector write is on the ROM port.
    assign loadDone    = (state_q == LOAD_VEC) && (colCnt_q == COUNT_N);
    assign fifoPop     = out_valid && out_ready;
    assign drainLast   = fifoPop && (outCnt_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept)                state_d = LOAD_MAT;
            LOAD_MAT: if (accept && lastMatElem) state_d = LOAD_VEC;
            LOAD_VEC: if (loadDone)              state_d = START;
            START:                               state_d = WAIT;
            WAIT:     if (compute_done)          state_d = DRAIN;
            DRAIN:    if (drainLast)             state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        start    = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE, LOAD_MAT: in_ready = rst;
            LOAD_VEC:       in_ready = rst && (colCnt_q != COUNT_N);
            START:          start    = rst;
            default: ;
        endcase
    end

    // Issue a read only if the FIFO will still have room once the in-flight read lands.
    always_comb begin
        rdIssue = 1'b0;
        if (state_q == DRAIN && rdCnt_q != COUNT_N) begin
            if (inflight_q) rdIssue = (fifoCount == 2'd0) || (fifoCount == 2'd1 && fifoPop);
            else            rdIssue = fifoPushReady;
        end
    end

    always_comb begin
        rowCnt_d   = rowCnt_q;
        colCnt_d   = colCnt_q;
        rdCnt_d    = rdCnt_q;
        outCnt_d   = outCnt_q;
        matWe_d    = '0;
        vecWe_d    = 1'b0;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        inflight_d = rdIssue;
        if (accept) begin
            wrData_d = in_data;
            wrAddr_d = AW'(colCnt_q);
            if (state_q == LOAD_VEC) begin
                vecWe_d  = 1'b1;
                colCnt_d = colCnt_q + 1'b1;
            end else begin
                matWe_d = {{(N-1){1'b0}}, 1'b1} << rowCnt_q;
                if (colCnt_q == LAST_IDX) begin
                    colCnt_d = '0;
                    rowCnt_d = (rowCnt_q == LAST_IDX) ? '0 : rowCnt_q + 1'b1;
                end else begin
                    colCnt_d = colCnt_q + 1'b1;
                end
            end
        end
        if (state_q == START) colCnt_d = '0;
        if (rdIssue)          rdCnt_d  = rdCnt_q + 1'b1;
        if (fifoPop)          outCnt_d = outCnt_q + 1'b1;
        if (drainLast) begin
            rdCnt_d  = '0;
            outCnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rowCnt_q   <= '0;
            colCnt_q   <= '0;
            rdCnt_q    <= '0;
            outCnt_q   <= '0;
            matWe_q    <= '0;
            vecWe_q    <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            rowCnt_q   <= rowCnt_d;
            colCnt_q   <= colCnt_d;
            rdCnt_q    <= rdCnt_d;
            outCnt_q   <= outCnt_d;
            matWe_q    <= matWe_d;
            vecWe_q    <= vecWe_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        for (int r = 0; r < N; r++) begin
            rom_mat_data[r]    = wrData_q;
            rom_mat_wr_addr[r] = wrAddr_q;
        end
    end

    assign rom_mat_we      = matWe_q;
    assign rom_vec_data    = wrData_q;
    assign rom_vec_wr_addr = wrAddr_q;
    assign rom_vec_we      = vecWe_q;
    assign ram_rd_addr     = (rdCnt_q == COUNT_N) ? '0 : AW'(rdCnt_q);

    mv_skid_fifo #(
        .W (RW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .pushValid_i (inflight_q),
        .pushData_i  (ram_data),
        .pushReady_o (fifoPushReady),
        .popValid_o  (out_valid),
        .popReady_i  (out_ready),
        .popData_o   (out_data),
        .count_o     (fifoCount)
    );

endmodule

// File: tb/tb_mv_stream_ctrl.sv
// Directed bench for mv_stream_ctrl: a 2x2/8-bit instance for load, drain, stall and reset
// sequences, and a 4x4/16-bit instance for full-width results.
module tb_mv_stream_ctrl;

    localparam int A_N = 2, A_DW = 8,  A_AW = 1, A_RW = 17;
    localparam int B_N = 4, B_DW = 16, B_AW = 2, B_RW = 34;

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic       expVec;
        int         expBank;
        int         expAddr;
    } loadRec_t;

    typedef struct {
        logic        isVec;
        int          bank;
        int          addr;
        logic [15:0] data;
        int          cyc;
    } wrEv_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    // Instance A signals
    logic                        aRst, aInValid, aInReady, aVecWe, aStart, aDone, aOutValid, aOutReady, aBusy;
    logic [A_DW-1:0]             aInData, aVecData;
    logic [A_N-1:0][A_DW-1:0]    aMatData;
    logic [A_N-1:0][A_AW-1:0]    aMatAddr;
    logic [A_N-1:0]              aMatWe;
    logic [A_AW-1:0]             aVecAddr, aRdAddr;
    logic [A_RW-1:0]             aRamData, aOutData;

    // Instance B signals
    logic                        bRst, bInValid, bInReady, bVecWe, bStart, bDone, bOutValid, bOutReady, bBusy;
    logic [B_DW-1:0]             bInData, bVecData;
    logic [B_N-1:0][B_DW-1:0]    bMatData;
    logic [B_N-1:0][B_AW-1:0]    bMatAddr;
    logic [B_N-1:0]              bMatWe;
    logic [B_AW-1:0]             bVecAddr, bRdAddr;
    logic [B_RW-1:0]             bRamData, bOutData;

    mv_stream_ctrl #(.N(A_N), .DW(A_DW), .BRAM_DEPTH(2)) dutA (
        .clk(clk), .rst(aRst), .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
        .rom_mat_data(aMatData), .rom_mat_wr_addr(aMatAddr), .rom_mat_we(aMatWe),
        .rom_vec_data(aVecData), .rom_vec_wr_addr(aVecAddr), .rom_vec_we(aVecWe),
        .start(aStart), .compute_done(aDone), .ram_rd_addr(aRdAddr), .ram_data(aRamData),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData), .busy(aBusy)
    );

    mv_stream_ctrl #(.N(B_N), .DW(B_DW), .BRAM_DEPTH(4)) dutB (
        .clk(clk), .rst(bRst), .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
        .rom_mat_data(bMatData), .rom_mat_wr_addr(bMatAddr), .rom_mat_we(bMatWe),
        .rom_vec_data(bVecData), .rom_vec_wr_addr(bVecAddr), .rom_vec_we(bVecWe),
        .start(bStart), .compute_done(bDone), .ram_rd_addr(bRdAddr), .ram_data(bRamData),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData), .busy(bBusy)
    );

    // Result RAM models (1-cycle read latency) and compute_done 5 cycles after start
    logic [A_RW-1:0] ramA [A_N];
    logic [B_RW-1:0] ramB [B_N];
    int   aDoneCnt = 0, bDoneCnt = 0;
    logic aDoneForce = 1'b0;

    always @(posedge clk) begin
        aRamData <= ramA[aRdAddr];
        bRamData <= ramB[bRdAddr];
        if (aStart) aDoneCnt <= 5;
        else if (aDoneCnt > 0) aDoneCnt <= aDoneCnt - 1;
        if (bStart) bDoneCnt <= 5;
        else if (bDoneCnt > 0) bDoneCnt <= bDoneCnt - 1;
    end
    assign aDone = (aDoneCnt == 1) || aDoneForce;
    assign bDone = (bDoneCnt == 1);

    // Event monitors
    wrEv_t       wrLogA[$], wrLogB[$];
    logic [63:0] outLogA[$], outLogB[$];
    int startCntA = 0, startCycA = 0, doneCycA = 0, hsCycA = 0, multiWeA = 0;
    int startCntB = 0, doneCycB = 0, hsCycB = 0, multiWeB = 0;

    always @(negedge clk) begin
        wrEv_t ev;
        if (($countones(aMatWe) + int'(aVecWe)) > 1) multiWeA++;
        for (int r = 0; r < A_N; r++) begin
            if (aMatWe[r]) begin
                ev.isVec = 1'b0; ev.bank = r; ev.addr = int'(aMatAddr[r]);
                ev.data = 16'(aMatData[r]); ev.cyc = cyc;
                wrLogA.push_back(ev);
            end
        end
        if (aVecWe) begin
            ev.isVec = 1'b1; ev.bank = 0; ev.addr = int'(aVecAddr);
            ev.data = 16'(aVecData); ev.cyc = cyc;
            wrLogA.push_back(ev);
        end
        if (aStart) begin startCntA++; startCycA = cyc; end
        if (aDone)  doneCycA = cyc;
        if (aOutValid && aOutReady) begin outLogA.push_back(64'(aOutData)); hsCycA = cyc; end
    end

    always @(negedge clk) begin
        wrEv_t ev;
        if (($countones(bMatWe) + int'(bVecWe)) > 1) multiWeB++;
        for (int r = 0; r < B_N; r++) begin
            if (bMatWe[r]) begin
                ev.isVec = 1'b0; ev.bank = r; ev.addr = int'(bMatAddr[r]);
                ev.data = bMatData[r]; ev.cyc = cyc;
                wrLogB.push_back(ev);
            end
        end
        if (bVecWe) begin
            ev.isVec = 1'b1; ev.bank = 0; ev.addr = int'(bVecAddr);
            ev.data = bVecData; ev.cyc = cyc;
            wrLogB.push_back(ev);
        end
        if (bStart) startCntB++;
        if (bDone)  doneCycB = cyc;
        if (bOutValid && bOutReady) begin outLogB.push_back(64'(bOutData)); hsCycB = cyc; end
    end

    loadRec_t tblA[6];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] packEv(input wrEv_t ev);
        return {31'b0, ev.isVec, 8'(ev.bank), 8'(ev.addr), ev.data};
    endfunction

    task automatic applyStimulus(input int count, input bit useGaps);
        for (int i = 0; i < count; i++) begin
            bit acc;
            if (useGaps) repeat (tblA[i].gap) begin aInValid = 1'b0; tick(); end
            aInValid = 1'b1;
            aInData  = tblA[i].data;
            acc = 1'b0;
            for (int g = 0; g < 20 && !acc; g++) begin acc = aInReady; tick(); end
            checkOutput($sformatf("accept%0d", i), 64'(acc), 64'd1);
        end
        aInValid = 1'b0;
    endtask

    task automatic checkWritesA(input bit fullRate);
        for (int g = 0; g < 30 && wrLogA.size() < 6; g++) tick();
        repeat (3) tick();
        checkOutput("wr_count", 64'(wrLogA.size()), 64'd6);
        for (int i = 0; i < 6 && i < wrLogA.size(); i++)
            checkOutput($sformatf("wr%0d", i), packEv(wrLogA[i]),
                        {31'b0, tblA[i].expVec, 8'(tblA[i].expBank), 8'(tblA[i].expAddr), 8'h00, tblA[i].data});
        if (fullRate && wrLogA.size() == 6)
            checkOutput("wr_no_bubble", 64'(wrLogA[5].cyc - wrLogA[0].cyc), 64'd5);
        checkOutput("one_we_at_a_time", 64'(multiWeA), 64'd0);
    endtask

    task automatic checkStartA();
        for (int g = 0; g < 20 && startCntA == 0; g++) tick();
        checkOutput("start_seen", 64'(startCntA), 64'd1);
        checkOutput("wait_in_ready", 64'(aInReady), 64'd0);
        checkOutput("wait_busy", 64'(aBusy), 64'd1);
        if (wrLogA.size() > 0)
            checkOutput("start_after_last_we", 64'(startCycA > wrLogA[wrLogA.size()-1].cyc), 64'd1);
    endtask

    task automatic drainA(input bit stall);
        if (stall) begin
            for (int g = 0; g < 60 && !aOutValid; g++) tick();
            checkOutput("stall_valid_seen", 64'(aOutValid), 64'd1);
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("stall_hold%0d", k), 64'(aOutData), 64'd17);
                checkOutput($sformatf("stall_valid%0d", k), 64'(aOutValid), 64'd1);
                tick();
            end
            aOutReady = 1'b1;
        end
        for (int g = 0; g < 60 && outLogA.size() < 2; g++) tick();
        checkOutput("drain_busy_low", 64'(aBusy), 64'd0);
        checkOutput("drain_valid_low", 64'(aOutValid), 64'd0);
        repeat (3) tick();
        checkOutput("drain_count", 64'(outLogA.size()), 64'd2);
        if (outLogA.size() >= 2) begin
            checkOutput("y0", outLogA[0], 64'd17);
            checkOutput("y1", outLogA[1], 64'd39);
        end
        if (!stall) checkOutput("drain_latency", 64'(hsCycA - doneCycA), 64'd4);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tblA[0] = '{8'd1, 0, 1'b0, 0, 0};
        tblA[1] = '{8'd2, 1, 1'b0, 0, 1};
        tblA[2] = '{8'd3, 0, 1'b0, 1, 0};
        tblA[3] = '{8'd4, 2, 1'b0, 1, 1};
        tblA[4] = '{8'd5, 1, 1'b1, 0, 0};
        tblA[5] = '{8'd6, 1, 1'b1, 0, 1};
        ramA[0] = 17'd17;
        ramA[1] = 17'd39;
        for (int k = 0; k < B_N; k++) ramB[k] = 34'h3_FFF8_0004 - 34'(k);

        aRst = 1'b0; aInValid = 1'b0; aInData = '0; aOutReady = 1'b1;
        bRst = 1'b0; bInValid = 1'b0; bInData = '0; bOutReady = 1'b1;
        repeat (3) tick();

        // Reset state
        checkOutput("rst_in_ready", 64'(aInReady), 64'd0);
        checkOutput("rst_busy", 64'(aBusy), 64'd0);
        checkOutput("rst_we", 64'({aMatWe, aVecWe}), 64'd0);
        checkOutput("rst_start", 64'(aStart), 64'd0);
        checkOutput("rst_out_valid", 64'(aOutValid), 64'd0);
        checkOutput("rst_addrs", 64'({aRdAddr, aVecAddr, aMatAddr}), 64'd0);
        checkOutput("rst_b_busy", 64'(bBusy), 64'd0);
        aRst = 1'b1; bRst = 1'b1;
        #1;
        checkOutput("idle_in_ready", 64'(aInReady), 64'd1);
        tick();

        $display("[TB] full-rate load and drain");
        applyStimulus(6, 1'b0);
        checkWritesA(1'b1);
        checkStartA();
        drainA(1'b0);

        aDoneForce = 1'b1;
        tick();
        aDoneForce = 1'b0;
        checkOutput("idle_done_ignored", 64'(aBusy), 64'd0);
        tick();
        checkOutput("idle_done_ignored2", 64'(aBusy), 64'd0);

        $display("[TB] gapped load with output stall");
        wrLogA.delete(); outLogA.delete(); startCntA = 0;
        aOutReady = 1'b0;
        applyStimulus(6, 1'b1);
        checkWritesA(1'b0);
        checkStartA();
        drainA(1'b1);

        $display("[TB] reset during vector load");
        wrLogA.delete(); outLogA.delete(); startCntA = 0;
        applyStimulus(5, 1'b0);
        checkOutput("pre_rst_busy", 64'(aBusy), 64'd1);
        aRst = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 64'(aInReady), 64'd0);
        tick();
        aRst = 1'b1;
        #1;
        checkOutput("post_rst_busy", 64'(aBusy), 64'd0);
        checkOutput("post_rst_we", 64'({aMatWe, aVecWe}), 64'd0);
        checkOutput("post_rst_in_ready", 64'(aInReady), 64'd1);
        repeat (12) tick();
        checkOutput("no_start_after_rst", 64'(startCntA), 64'd0);
        wrLogA.delete(); outLogA.delete(); startCntA = 0;
        applyStimulus(6, 1'b0);
        checkWritesA(1'b1);
        checkStartA();
        drainA(1'b0);

        $display("[TB] N=4 DW=16 max-value load and drain");
        bInValid = 1'b1;
        bInData  = 16'hFFFF;
        for (int i = 0; i < B_N * B_N + B_N; i++) begin
            bit acc;
            acc = 1'b0;
            for (int g = 0; g < 20 && !acc; g++) begin acc = bInReady; tick(); end
            checkOutput($sformatf("b_accept%0d", i), 64'(acc), 64'd1);
        end
        bInValid = 1'b0;
        for (int g = 0; g < 60 && outLogB.size() < B_N; g++) tick();
        checkOutput("b_busy_low", 64'(bBusy), 64'd0);
        checkOutput("b_wr_count", 64'(wrLogB.size()), 64'd20);
        for (int i = 0; i < 20 && i < wrLogB.size(); i++) begin
            logic [63:0] exp;
            if (i < 16) exp = {31'b0, 1'b0, 8'(i / 4), 8'(i % 4), 16'hFFFF};
            else        exp = {31'b0, 1'b1, 8'd0, 8'(i - 16), 16'hFFFF};
            checkOutput($sformatf("b_wr%0d", i), packEv(wrLogB[i]), exp);
        end
        checkOutput("b_one_we", 64'(multiWeB), 64'd0);
        checkOutput("b_start_count", 64'(startCntB), 64'd1);
        checkOutput("b_out_count", 64'(outLogB.size()), 64'd4);
        for (int k = 0; k < B_N && k < outLogB.size(); k++)
            checkOutput($sformatf("b_y%0d", k), outLogB[k], 64'(34'h3_FFF8_0004 - 34'(k)));
        checkOutput("b_drain_latency", 64'(hsCycB - doneCycB), 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
